// File: rtl/adc_sample_scheduler_pkg.sv
// Shared types and constants for the MCP3201 sample scheduler.
package adc_ctrl_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    SHIFT    = 2'd2,
    CS_REC   = 2'd3
  } adc_state_e;

  // Serial-clock pulses that precede the data bits: two sample-phase bits plus the null bit.
  localparam int N_LEAD = 3;

  // Default conversion width of the MCP3201.
  localparam int N_BITS_DEFAULT = 12;

  // Counter width able to index 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_sample_scheduler_if.sv
// Sample hand-off bus between the ADC scheduler and the serial transmit path.
interface adc_sample_scheduler_if #(
  parameter int N_BITS = 12
) ();

  logic [N_BITS-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;

  modport master (output sample_data, output sample_valid, input sample_ready);
  modport slave  (input sample_data, input sample_valid, output sample_ready);

endinterface

// File: rtl/adc_sample_scheduler_sclk_gen.sv
// Serial-clock divider: half-period ticks and the registered ADC serial clock.
module adc_sclk_gen
  import adc_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,         // divider counts only while a frame owns the bus
  input  logic allow_rise,  // low suppresses the rise after the final pulse
  output logic rise_tick,   // last cycle of a low half-period
  output logic fall_tick,   // last cycle of a high half-period
  output logic sclk
);

  localparam int               DIV_W    = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             tick_s;

  // Half-period tick decode and next divider / serial-clock values.
  always_comb begin
    tick_s    = run && (div_q == DIV_LAST);
    rise_tick = tick_s && !sclk_q;
    fall_tick = tick_s && sclk_q;
    div_d     = div_q;
    sclk_d    = sclk_q;
    if (!run) begin
      div_d  = '0;
      sclk_d = 1'b0;
    end else begin
      if (tick_s) begin
        div_d = '0;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
      if (fall_tick) begin
        sclk_d = 1'b0;
      end else if (rise_tick && allow_rise) begin
        sclk_d = 1'b1;
      end else begin
        sclk_d = sclk_q;
      end
    end
  end

  // Divider and serial-clock registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/adc_sample_scheduler.sv
// MCP3201 frame sequencer: trigger scheduling, bit capture and one-entry sample buffer.
module adc_sample_scheduler
  import adc_ctrl_pkg::*;
#(
  parameter int N_BITS      = N_BITS_DEFAULT,
  parameter int CLK_DIV     = 4,
  parameter int RATE_DIV    = 10000,
  parameter int CS_HIGH_MIN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic start,
  input  logic adc_dout,
  output logic adc_cs_n,
  output logic adc_sclk,
  output logic busy,
  output logic overrun,
  output logic null_err,
  adc_sample_scheduler_if.master smp
);

  localparam int BIT_W  = cnt_width(N_BITS + N_LEAD);
  localparam int RATE_W = cnt_width(RATE_DIV);
  localparam int REC_W  = cnt_width(CS_HIGH_MIN + 1);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N_BITS + N_LEAD - 1);
  localparam logic [BIT_W-1:0]  NULL_IDX  = BIT_W'(N_LEAD - 1);
  localparam logic [BIT_W-1:0]  DATA_IDX  = BIT_W'(N_LEAD);
  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(RATE_DIV - 1);
  localparam logic [REC_W-1:0]  REC_LAST  = REC_W'(CS_HIGH_MIN - 1);

  adc_state_e        state_q, state_d;
  logic              pending_q, pending_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [REC_W-1:0]  rec_q, rec_d;
  logic [N_BITS-1:0] shift_q, shift_d;
  logic [N_BITS-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              null_err_q, null_err_d;

  logic trigger_s, launch_s, commit_s, accept_s, capture_s;
  logic rise_tick_s, fall_tick_s, sclk_run_s, allow_rise_s, sclk_s;

  // The divider runs from chip-select assertion until the last low phase ends.
  always_comb begin
    sclk_run_s   = (state_q == CS_SETUP) || (state_q == SHIFT);
    allow_rise_s = !((state_q == SHIFT) && (bit_q == BIT_LAST));
  end

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (sclk_run_s),
    .allow_rise (allow_rise_s),
    .rise_tick  (rise_tick_s),
    .fall_tick  (fall_tick_s),
    .sclk       (sclk_s)
  );

  // Periodic rate timer; parked at zero while disabled. Start is honoured regardless of enable.
  always_comb begin
    if (enable) begin
      if (rate_q == RATE_LAST) begin
        rate_d = '0;
      end else begin
        rate_d = rate_q + RATE_W'(1);
      end
    end else begin
      rate_d = '0;
    end
    trigger_s = start || (enable && (rate_q == RATE_LAST));
  end

  // Next-state logic of the frame sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pending_q || trigger_s) state_d = CS_SETUP;
        else                        state_d = IDLE;
      end
      CS_SETUP: begin
        if (rise_tick_s) state_d = SHIFT;
        else             state_d = CS_SETUP;
      end
      SHIFT: begin
        if (rise_tick_s && (bit_q == BIT_LAST)) state_d = CS_REC;
        else                                    state_d = SHIFT;
      end
      CS_REC: begin
        if (rec_q == REC_LAST) state_d = IDLE;
        else                   state_d = CS_REC;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered pin and status values follow the state being entered.
  always_comb begin
    cs_n_d = !((state_d == CS_SETUP) || (state_d == SHIFT));
    busy_d = (state_d != IDLE);
  end

  // Pending trigger, bit/recovery counters, shift register and sample buffer.
  always_comb begin
    launch_s  = (state_q == IDLE) && (state_d == CS_SETUP);
    commit_s  = (state_q == SHIFT) && (state_d == CS_REC);
    capture_s = (state_q == SHIFT) && fall_tick_s;
    accept_s  = valid_q && smp.sample_ready;

    // A trigger in the launch cycle is absorbed by the frame being launched.
    if (launch_s) begin
      pending_d = 1'b0;
    end else if (trigger_s) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    // bit_q indexes the current pulse; it advances on each rise after the first.
    if (state_q == SHIFT) begin
      if (rise_tick_s && (bit_q != BIT_LAST)) bit_d = bit_q + BIT_W'(1);
      else                                    bit_d = bit_q;
    end else begin
      bit_d = '0;
    end

    if ((state_q == CS_REC) && (state_d == CS_REC)) rec_d = rec_q + REC_W'(1);
    else                                            rec_d = '0;

    if (capture_s && (bit_q >= DATA_IDX)) shift_d = {shift_q[N_BITS-2:0], adc_dout};
    else                                  shift_d = shift_q;

    null_err_d = capture_s && (bit_q == NULL_IDX) && adc_dout;

    // A commit may reuse the slot being drained in the same cycle.
    data_d    = data_q;
    overrun_d = 1'b0;
    if (commit_s && (!valid_q || smp.sample_ready)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (commit_s) begin
      overrun_d = 1'b1;
      valid_d   = valid_q;
    end else if (accept_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q  <= 1'b0;
      rate_q     <= '0;
      bit_q      <= '0;
      rec_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      null_err_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      rate_q     <= rate_d;
      bit_q      <= bit_d;
      rec_q      <= rec_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      null_err_q <= null_err_d;
    end
  end

  assign adc_cs_n         = cs_n_q;
  assign adc_sclk         = sclk_s;
  assign busy             = busy_q;
  assign overrun          = overrun_q;
  assign null_err         = null_err_q;
  assign smp.sample_data  = data_q;
  assign smp.sample_valid = valid_q;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed/randomized bench for adc_sample_scheduler with an MCP3201 pin model.
module tb_adc_sample_scheduler;

  localparam int N_BITS      = 12;
  localparam int CLK_DIV     = 4;
  localparam int RATE_DIV    = 300;
  localparam int CS_HIGH_MIN = 8;
  localparam int FRAME_LOW   = CLK_DIV * (2 * (N_BITS + 3) + 1);
  localparam int N_PULSES    = N_BITS + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic start = 1'b0;
  logic adc_dout = 1'b0;
  logic adc_cs_n, adc_sclk, busy, overrun, null_err;

  adc_sample_scheduler_if #(.N_BITS(N_BITS)) smp_if ();

  adc_sample_scheduler #(
    .N_BITS      (N_BITS),
    .CLK_DIV     (CLK_DIV),
    .RATE_DIV    (RATE_DIV),
    .CS_HIGH_MIN (CS_HIGH_MIN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .start    (start),
    .adc_dout (adc_dout),
    .adc_cs_n (adc_cs_n),
    .adc_sclk (adc_sclk),
    .busy     (busy),
    .overrun  (overrun),
    .null_err (null_err),
    .smp      (smp_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  // ADC stimulus controls written only by the main sequence.
  logic              fixed_en = 1'b1;
  logic [N_BITS-1:0] fixed_word = '0;
  logic              fixed_null = 1'b0;
  logic              mon_en = 1'b0;

  // ADC pin model: new word at chip-select fall, one bit presented after each sclk rise.
  int                pidx = 0;
  logic [N_BITS-1:0] cur_word = '0;
  logic              cur_null = 1'b0;
  int                exp_words[$];

  always @(posedge adc_sclk or negedge adc_cs_n) begin : adc_model
    logic [N_BITS-1:0] w;
    if (adc_sclk) begin
      if (pidx < 2)       adc_dout <= 1'($urandom);
      else if (pidx == 2) adc_dout <= cur_null;
      else                adc_dout <= cur_word[N_BITS + 2 - pidx];
      pidx <= pidx + 1;
    end else begin
      if (fixed_en) w = fixed_word;
      else          w = N_BITS'($urandom);
      cur_word <= w;
      cur_null <= fixed_en ? fixed_null : 1'b0;
      pidx     <= 0;
      exp_words.push_back(int'(w));
    end
  end

  // Bus monitor: frame starts, low lengths, high gaps, pulse counts, flags, accepted samples.
  logic cs_prev = 1'b1;
  logic sclk_prev = 1'b0;
  int   last_fall = 0;
  int   last_rise = 0;
  logic seen_rise = 1'b0;
  int   pulse_cnt = 0;
  int   ovr_cnt = 0;
  int   null_cnt = 0;
  int   start_q[$];
  int   low_q[$];
  int   gap_q[$];
  int   pulse_q[$];
  int   acc_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (cs_prev && !adc_cs_n) begin
        start_q.push_back(cyc);
        if (seen_rise) gap_q.push_back(cyc - last_rise);
        last_fall <= cyc;
        pulse_cnt <= 0;
      end else if (!sclk_prev && adc_sclk) begin
        pulse_cnt <= pulse_cnt + 1;
      end
      if (!cs_prev && adc_cs_n) begin
        low_q.push_back(cyc - last_fall);
        pulse_q.push_back(pulse_cnt);
        last_rise <= cyc;
        seen_rise <= 1'b1;
      end
      if (overrun)  ovr_cnt  <= ovr_cnt + 1;
      if (null_err) null_cnt <= null_cnt + 1;
      if (smp_if.sample_valid && smp_if.sample_ready) acc_q.push_back(int'(smp_if.sample_data));
      cs_prev   <= adc_cs_n;
      sclk_prev <= adc_sclk;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ns, na, ne, ovr0, nul0, d;
    logic [N_BITS-1:0] w;
    smp_if.sample_ready = 1'b0;

    // Reset values
    tick(2);
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_sclk", adc_sclk, 0);
    check("rst_data", smp_if.sample_data, 0);
    check("rst_valid", smp_if.sample_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_null_err", null_err, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick(3);

    // Single shot returning 0xA5C
    fixed_word = 12'hA5C;
    fixed_null = 1'b0;
    ovr0 = ovr_cnt;
    nul0 = null_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("a_cs_latency", adc_cs_n, 0);
    tick(FRAME_LOW - 1);
    check("a_cs_last_low", adc_cs_n, 0);
    check("a_valid_early", smp_if.sample_valid, 0);
    tick(1);
    check("a_cs_high", adc_cs_n, 1);
    check("a_valid", smp_if.sample_valid, 1);
    check("a_data", smp_if.sample_data, 12'hA5C);
    tick(CS_HIGH_MIN - 1);
    check("a_busy_rec", busy, 1);
    tick(1);
    check("a_busy_fall", busy, 0);
    check("a_low_len", low_q[$], FRAME_LOW);
    check("a_pulses", pulse_q[$], N_PULSES);
    check("a_no_overrun", ovr_cnt - ovr0, 0);
    check("a_no_null", null_cnt - nul0, 0);
    smp_if.sample_ready = 1'b1;
    tick(1);
    smp_if.sample_ready = 1'b0;
    check("a_consumed", smp_if.sample_valid, 0);
    check("a_acc", acc_q[$], 12'hA5C);

    // Null bit reads 1: flagged once, data still captured
    w = N_BITS'($urandom);
    fixed_word = w;
    fixed_null = 1'b1;
    nul0 = null_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(140);
    check("n_null_pulse", null_cnt - nul0, 1);
    check("n_data", smp_if.sample_data, w);
    check("n_valid", smp_if.sample_valid, 1);
    smp_if.sample_ready = 1'b1;
    tick(1);
    smp_if.sample_ready = 1'b0;
    check("n_consumed", smp_if.sample_valid, 0);
    fixed_null = 1'b0;

    // Consumer stalled across two frames: second sample dropped
    ovr0 = ovr_cnt;
    fixed_word = 12'h123;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(140);
    fixed_word = 12'h456;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(140);
    check("o_data_kept", smp_if.sample_data, 12'h123);
    check("o_valid", smp_if.sample_valid, 1);
    check("o_overrun_once", ovr_cnt - ovr0, 1);

    // Reset 60 cycles into a frame, with an unconsumed sample held
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(59);
    rst_n = 1'b0;
    tick(1);
    check("r_cs_n", adc_cs_n, 1);
    check("r_sclk", adc_sclk, 0);
    check("r_valid", smp_if.sample_valid, 0);
    check("r_data", smp_if.sample_data, 0);
    check("r_busy", busy, 0);
    rst_n = 1'b1;
    tick(2);
    w = N_BITS'($urandom);
    fixed_word = w;
    smp_if.sample_ready = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("r2_cs_latency", adc_cs_n, 0);
    tick(FRAME_LOW);
    check("r2_valid", smp_if.sample_valid, 1);
    check("r2_data", smp_if.sample_data, w);
    tick(CS_HIGH_MIN + 1);
    check("r2_low_len", low_q[$], FRAME_LOW);
    check("r2_pulses", pulse_q[$], N_PULSES);
    check("r2_acc", acc_q[$], w);
    check("r2_drained", smp_if.sample_valid, 0);

    // Starts during a frame merge into one pending trigger; frames run back to back
    fixed_en = 1'b0;
    ns = start_q.size();
    na = acc_q.size();
    ne = exp_words.size();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    d = int'($urandom_range(1, 100));
    tick(d);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(300);
    check("m_frames", start_q.size() - ns, 2);
    // one IDLE cycle separates the recovery window from the next launch
    check("m_start_gap", start_q[ns + 1] - start_q[ns], FRAME_LOW + CS_HIGH_MIN + 1);
    check("m_cs_high", gap_q[$], CS_HIGH_MIN + 1);
    check("m_low_len", low_q[$], FRAME_LOW);
    check("m_acc_count", acc_q.size() - na, 2);
    check("m_acc0", acc_q[na], exp_words[ne]);
    check("m_acc1", acc_q[na + 1], exp_words[ne + 1]);

    // Periodic mode with the consumer always ready
    ns = start_q.size();
    na = acc_q.size();
    ne = exp_words.size();
    ovr0 = ovr_cnt;
    enable = 1'b1;
    tick(2000);
    enable = 1'b0;
    tick(300);
    check("p_frames", start_q.size() - ns, 2000 / RATE_DIV);
    for (int i = 1; i < 2000 / RATE_DIV; i++) begin
      check("p_period", start_q[ns + i] - start_q[ns + i - 1], RATE_DIV);
    end
    check("p_acc_count", acc_q.size() - na, 2000 / RATE_DIV);
    for (int i = 0; i < 2000 / RATE_DIV; i++) begin
      check("p_value", acc_q[na + i], exp_words[ne + i]);
    end
    check("p_no_overrun", ovr_cnt - ovr0, 0);
    check("p_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
